// File: rtl/fifo_rr_scheduler.sv
// Round-robin write arbiter into a shared FIFO plus a latency-aware read drain into a skid buffer.
// Write grant is combinational; read data lands LATENCY cycles after fifo_read; reads stop when the skid buffer could overflow.
module fifo_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    output logic                          fifo_read,
    input  logic [DATA_WIDTH-1:0]         fifo_read_data,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ready
);

    localparam int SKID_DEPTH = LATENCY + 1;
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = $clog2(SKID_DEPTH + 1);

    // ---------------- write side ----------------
    logic [IW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] rot;
    logic               found;
    logic [IW-1:0]      off;
    logic [SW-1:0]      sum;
    logic [IW-1:0]      win_id;
    logic               grant;

    // Rotate requests so bit 0 is the requester at rr_ptr, then take the first set bit.
    always_comb begin
        rot   = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= SW'(NUM_REQ)) begin
            sum = sum - SW'(NUM_REQ);
        end
    end

    assign win_id     = sum[IW-1:0];
    assign grant      = found && !fifo_full;
    assign fifo_write = grant;
    assign grant_id   = grant ? win_id : '0;

    always_comb begin
        req_ready       = '0;
        fifo_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && win_id == IW'(i)) begin
                req_ready[i]    = 1'b1;
                fifo_write_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (win_id == IW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    // ---------------- read side ----------------
    logic [LATENCY-1:0]    rd_sr;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         skid_count;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [CW:0]           occ;
    logic                  push;
    logic                  pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            in_flight = in_flight + CW'(rd_sr[i]);
        end
    end

    assign push      = rd_sr[LATENCY-1];
    assign out_valid = !reset && (skid_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = skid_mem[head];

    // Every issued read owns a skid slot; a slot freed by this cycle's pop may be reused.
    assign occ       = {1'b0, in_flight} + {1'b0, skid_count} - {{CW{1'b0}}, pop};
    assign fifo_read = !reset && !fifo_empty && (occ < (CW+1)'(SKID_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sr      <= '0;
            skid_count <= '0;
            head       <= '0;
            tail       <= '0;
        end else begin
            rd_sr <= {rd_sr[LATENCY-2:0], fifo_read};
            if (push) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            if (push && !pop) begin
                skid_count <= skid_count + 1'b1;
            end else if (pop && !push) begin
                skid_count <= skid_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            skid_mem[tail] <= fifo_read_data;
        end
    end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write requesters (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: word width.
REQ-003 SHALL have parameter LATENCY, default 2: FIFO read latency, cycles from fifo_read to valid fifo_read_data (min 2).
REQ-004 SHALL have localparam SKID_DEPTH = LATENCY+1: output buffer entries.
REQ-005 SHALL have port clk  in  1: clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1: reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  in  NUM_REQ: per-requester write request.
REQ-008 SHALL have port req_data  in  NUM_REQ*DATA_WIDTH: requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_ready  out  NUM_REQ: one-hot grant; word accepted when valid&ready.
REQ-010 SHALL have port grant_id  out  $clog2(NUM_REQ): index of current grant, 0 when none.
REQ-011 SHALL have port fifo_write  out  1, fifo_write_data  out  DATA_WIDTH: shared FIFO write side.
REQ-012 SHALL have port fifo_full  in  1, fifo_empty  in  1: shared FIFO flags.
REQ-013 SHALL have port fifo_read  out  1, fifo_read_data  in  DATA_WIDTH: shared FIFO read side.
REQ-014 SHALL have port out_valid  out  1, out_data  out  DATA_WIDTH, out_ready  in  1: downstream valid/ready stream.

Function
REQ-015 Write arbitration SHALL be combinational round-robin: search starts at rr_ptr, first i with req_valid[i] wins.
REQ-016 When fifo_full=1 all req_ready SHALL be 0, fifo_write 0, rr_ptr held.
REQ-017 When fifo_full=0 and any req_valid: exactly one req_ready bit 1, fifo_write=1, fifo_write_data=req_data of winner, grant_id=winner.
REQ-018 No req_valid: fifo_write=0, req_ready=0, rr_ptr held.
REQ-019 On accepted write by winner g, rr_ptr SHALL load (g+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
REQ-020 Read side SHALL track in_flight (reads issued, data not yet returned) via a LATENCY-stage valid shift register; stage LATENCY-1 set = data returning this cycle.
REQ-021 pop = out_valid & out_ready; push = returning stage valid.
REQ-022 fifo_read SHALL be 1 iff fifo_empty=0 and (in_flight + skid_count - pop) < SKID_DEPTH; never asserted while fifo_empty=1.
REQ-023 On push, fifo_read_data SHALL be written into the skid buffer tail in issue order.
REQ-024 out_valid = (skid_count != 0); out_data = skid buffer head, held stable while out_valid & !out_ready.
REQ-025 Simultaneous push and pop: count unchanged, head advances, tail advances; push with count=SKID_DEPTH SHALL never occur (guaranteed by REQ-022).
REQ-026 With out_ready held 1 and FIFO non-empty, sustained throughput SHALL be one word per cycle after initial LATENCY+1 cycle fill.
REQ-027 Counter widths SHALL cover 0..SKID_DEPTH without overflow; skid pointers wrap modulo SKID_DEPTH.
REQ-028 Write and read sides SHALL operate independently in the same cycle.

Reset
REQ-029 On reset: rr_ptr=0, valid shift register cleared, skid_count=0, skid pointers=0.
REQ-030 During and after reset cycle: out_valid=0, fifo_read=0; req_ready/fifo_write follow REQ-016..018 combinationally.
REQ-031 Reset mid-operation SHALL discard in-flight reads and buffered words; no stale word emitted afterwards.

Verification
REQ-032 All 4 req_valid=1, fifo_full=0, 8 cycles -> grants 0,1,2,3,0,1,2,3; each requester gets exactly 2 writes.
REQ-033 req_valid=4'b1010, rr_ptr=2 -> grant 3 then 1 then 3; fifo_full=1 for 3 cycles mid-sequence -> req_ready=0, order resumes unchanged.
REQ-034 FIFO preloaded with 0x01..0x10, out_ready=1 -> out_data 0x01..0x10 consecutive cycles, first out_valid LATENCY+1 cycles after first fifo_read.
REQ-035 Same preload, out_ready=0 for 10 cycles -> exactly SKID_DEPTH reads issued, out_data=0x01 stable; release -> no loss, no duplicate.
REQ-036 fifo_empty=1 throughout -> fifo_read never 1, out_valid stays 0.
REQ-037 Reset asserted with 2 reads in flight and 1 buffered word -> out_valid=0 next cycle, no old data ever appears; post-reset grant starts at requester 0.
